// File: rtl/game_ctrl_fsmd.sv
// rtl/game_ctrl_fsmd.sv - game-control FSMD: game sequencing, BCD score, ball reserve, frame timer, layered RGB pixel
// Optional pause mode: define GAME_PAUSE_EN.
module game_ctrl_fsmd #(
    parameter int               BALLS        = 3,
    parameter int               SCORE_DIGITS = 2,
    parameter int               TIMER_FRAMES = 120,
    parameter int               RGB_W        = 3,
    parameter logic [RGB_W-1:0] BG_COLOR     = RGB_W'(3'b110)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                btn,
    input  logic                      pause_btn,
    input  logic                      pixel_tick,
    input  logic                      frame_tick,
    input  logic                      video_on,
    input  logic                      hit,
    input  logic                      miss,
    input  logic [3:0]                text_on,
    input  logic [RGB_W-1:0]          text_rgb,
    input  logic                      graph_on,
    input  logic [RGB_W-1:0]          graph_rgb,
    output logic [RGB_W-1:0]          rgb,
    output logic                      gra_still,
    output logic [4*SCORE_DIGITS-1:0] score,
    output logic [3:0]                balls_left,
    output logic [2:0]                state
);

    localparam int              SW         = 4 * SCORE_DIGITS;
    localparam logic [3:0]      BALLS_INIT = 4'(BALLS);
    localparam logic [9:0]      TIMER_LOAD = 10'(TIMER_FRAMES);

    typedef enum logic [2:0] {
        S_NEWGAME = 3'b000,
        S_PLAY    = 3'b001,
        S_NEWBALL = 3'b010,
`ifdef GAME_PAUSE_EN
        S_OVER    = 3'b011,
        S_PAUSE   = 3'b100
`else
        S_OVER    = 3'b011
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    score_q, score_d;
    logic [3:0]       balls_q, balls_d;
    logic [9:0]       timer_q, timer_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             btn_q;
    logic             press;
    logic             pause_press;
    logic             frozen;
    logic             timer_up;
    logic             load;

    // Saturating BCD increment: an all-9s score stays put rather than wrapping.
    function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
        logic [SW-1:0] r;
        logic          carry;
        logic          all9;
        r     = v;
        carry = 1'b1;
        all9  = 1'b1;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            if (v[4*i +: 4] != 4'd9) all9 = 1'b0;
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return all9 ? v : r;
    endfunction

    // Edge detector copy resets high so a button held through reset is not a press.
    assign press    = (|btn) & ~btn_q;
    assign timer_up = (timer_q == 10'd0);

`ifdef GAME_PAUSE_EN
    logic pause_q;
    assign pause_press = pause_btn & ~pause_q;
    assign frozen      = (state_q == S_PAUSE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pause_q <= 1'b1;
        else       pause_q <= pause_btn;
    end
`else
    logic unused_pause;
    assign unused_pause = pause_btn;
    assign pause_press  = 1'b0;
    assign frozen       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        balls_d = balls_q;
        load    = 1'b0;
        case (state_q)
            S_NEWGAME: begin
                score_d = '0;
                balls_d = BALLS_INIT;
                if (press) begin
                    state_d = S_PLAY;
                    balls_d = BALLS_INIT - 4'd1;
                end
            end
            S_PLAY: begin
                if (pause_press) begin
`ifdef GAME_PAUSE_EN
                    state_d = S_PAUSE;
`endif
                end else begin
                    if (hit) score_d = bcd_inc(score_q);
                    if (miss) begin
                        load = 1'b1;
                        if (balls_q == 4'd0) begin
                            state_d = S_OVER;
                        end else begin
                            state_d = S_NEWBALL;
                            balls_d = balls_q - 4'd1;
                        end
                    end
                end
            end
            S_NEWBALL: begin
                if (timer_up && press) state_d = S_PLAY;
            end
            S_OVER: begin
                if (timer_up) state_d = S_NEWGAME;
            end
`ifdef GAME_PAUSE_EN
            S_PAUSE: begin
                if (pause_press) state_d = S_PLAY;
            end
`endif
            default: state_d = S_NEWGAME;
        endcase
    end

    // A load beats a coincident frame_tick decrement.
    always_comb begin
        timer_d = timer_q;
        if (load)
            timer_d = TIMER_LOAD;
        else if (frame_tick && !timer_up && !frozen)
            timer_d = timer_q - 10'd1;
    end

    always_comb begin
        rgb_d = BG_COLOR;
        if (!video_on)
            rgb_d = '0;
        else if (text_on[3] || (state_q == S_NEWGAME && text_on[1]) ||
                 (state_q == S_OVER && text_on[0]))
            rgb_d = text_rgb;
        else if (graph_on)
            rgb_d = graph_rgb;
        else if (text_on[2])
            rgb_d = text_rgb;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_NEWGAME;
            score_q <= '0;
            balls_q <= BALLS_INIT;
            timer_q <= 10'd0;
            rgb_q   <= '0;
            btn_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            balls_q <= balls_d;
            timer_q <= timer_d;
            btn_q   <= |btn;
            if (pixel_tick) rgb_q <= rgb_d;
        end
    end

    assign rgb        = rgb_q;
    assign score      = score_q;
    assign balls_left = balls_q;
    assign state      = state_q;
    assign gra_still  = (state_q != S_PLAY);

endmodule

// File: tb/tb_game_ctrl_fsmd.sv
// tb/tb_game_ctrl_fsmd.sv - self-checking bench for game_ctrl_fsmd (directed, table and randomized vs model)
module tb_game_ctrl_fsmd;

    localparam int         BALLS = 3;
    localparam int         SD    = 2;
    localparam int         TF    = 120;
    localparam int         MAXS  = 99;
`ifdef GAME_PAUSE_EN
    localparam bit         PAUSE_EN = 1'b1;
`else
    localparam bit         PAUSE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] btn;
    logic       pause_btn, pixel_tick, frame_tick, video_on, hit, miss, graph_on;
    logic [3:0] text_on;
    logic [2:0] text_rgb, graph_rgb, rgb;
    logic       gra_still;
    logic [7:0] score;
    logic [3:0] balls_left;
    logic [2:0] state;

    game_ctrl_fsmd #(.BALLS(BALLS), .SCORE_DIGITS(SD), .TIMER_FRAMES(TF),
                     .RGB_W(3), .BG_COLOR(3'b110)) dut (
        .clk(clk), .reset(reset), .btn(btn), .pause_btn(pause_btn),
        .pixel_tick(pixel_tick), .frame_tick(frame_tick), .video_on(video_on),
        .hit(hit), .miss(miss), .text_on(text_on), .text_rgb(text_rgb),
        .graph_on(graph_on), .graph_rgb(graph_rgb), .rgb(rgb),
        .gra_still(gra_still), .score(score), .balls_left(balls_left), .state(state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            frame_tick = 1'b1; tick();
            frame_tick = 1'b0; tick();
        end
    endtask

    task automatic pulse_hit();
        hit = 1'b1; tick(); hit = 1'b0; tick();
    endtask

    // Behavioural reference: mode uses the externally visible state codes.
    int m_mode, m_score, m_balls, m_timer;
    bit m_prev, m_pprev;

    task automatic model_reset();
        m_mode = 0; m_score = 0; m_balls = BALLS; m_timer = 0;
        m_prev = 1'b1; m_pprev = 1'b1;
    endtask

    task automatic model_step();
        bit press, pp, load;
        int nm;
        press   = (btn != 2'b00) && !m_prev;
        m_prev  = (btn != 2'b00);
        pp      = pause_btn && !m_pprev;
        m_pprev = pause_btn;
        load    = 1'b0;
        nm      = m_mode;
        case (m_mode)
            0: begin
                m_score = 0; m_balls = BALLS;
                if (press) begin nm = 1; m_balls = BALLS - 1; end
            end
            1: begin
                if (PAUSE_EN && pp) nm = 4;
                else begin
                    if (hit && m_score < MAXS) m_score = m_score + 1;
                    if (miss) begin
                        load = 1'b1;
                        if (m_balls == 0) nm = 3;
                        else begin nm = 2; m_balls = m_balls - 1; end
                    end
                end
            end
            2: if (m_timer == 0 && press) nm = 1;
            3: if (m_timer == 0) nm = 0;
            4: if (pp) nm = 1;
            default: nm = 0;
        endcase
        if (load) m_timer = TF;
        else if (frame_tick && m_timer > 0 && m_mode != 4) m_timer = m_timer - 1;
        m_mode = nm;
    endtask

    function automatic logic [7:0] to_bcd(input int s);
        logic [7:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < SD; i++) begin
            r[4*i +: 4] = 4'((s / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    typedef struct {
        bit         play;
        logic       vid;
        logic [3:0] txt;
        logic       gon;
        logic [2:0] exp_rgb;
    } rgb_vec_t;

    rgb_vec_t   vecs[11];
    logic [2:0] prev_rgb;

    initial begin
        vecs[0]  = '{0, 1'b0, 4'b1111, 1'b1, 3'b000};
        vecs[1]  = '{0, 1'b1, 4'b0010, 1'b1, 3'b101};
        vecs[2]  = '{0, 1'b1, 4'b0001, 1'b1, 3'b011};
        vecs[3]  = '{0, 1'b1, 4'b1000, 1'b1, 3'b101};
        vecs[4]  = '{0, 1'b1, 4'b0100, 1'b0, 3'b101};
        vecs[5]  = '{0, 1'b1, 4'b0000, 1'b0, 3'b110};
        vecs[6]  = '{1, 1'b1, 4'b0010, 1'b1, 3'b011};
        vecs[7]  = '{1, 1'b1, 4'b0100, 1'b1, 3'b011};
        vecs[8]  = '{1, 1'b1, 4'b0110, 1'b0, 3'b101};
        vecs[9]  = '{1, 1'b1, 4'b1000, 1'b1, 3'b101};
        vecs[10] = '{1, 1'b1, 4'b0000, 1'b0, 3'b110};

        reset = 1'b1; btn = 2'b01; pause_btn = 1'b0; pixel_tick = 1'b0;
        frame_tick = 1'b0; video_on = 1'b0; hit = 1'b0; miss = 1'b0;
        text_on = 4'b0000; text_rgb = 3'b101; graph_on = 1'b0; graph_rgb = 3'b011;

        // Button held through reset is not a press
        #12;
        chk("reset_state", state, 3'b000);
        chk("reset_score", score, 8'h00);
        chk("reset_balls", balls_left, 4'd3);
        chk("reset_still", gra_still, 1'b1);
        chk("reset_rgb", rgb, 3'b000);
        tick();
        reset = 1'b0;
        tick(); tick(); tick();
        chk("held_btn_no_press", state, 3'b000);
        btn = 2'b00; tick();
        btn = 2'b10; tick();
        chk("press_play_state", state, 3'b001);
        chk("press_play_balls", balls_left, 4'd2);
        chk("press_play_still", gra_still, 1'b0);
        btn = 2'b00;

        // Score BCD counting and saturation
        repeat (12) pulse_hit();
        chk("score_12", score, 8'h12);
        repeat (87) pulse_hit();
        chk("score_99", score, 8'h99);
        pulse_hit();
        chk("score_sat", score, 8'h99);

        // Misses, timer gating of presses, game over
        miss = 1'b1; tick(); miss = 1'b0;
        chk("miss1_state", state, 3'b010);
        chk("miss1_balls", balls_left, 4'd1);
        chk("newball_still", gra_still, 1'b1);
        miss = 1'b1; tick(); miss = 1'b0; tick();
        chk("miss_ignored_newball", balls_left, 4'd1);
        frames(60);
        btn = 2'b01; tick();
        chk("press_timer_busy", state, 3'b010);
        btn = 2'b00; tick();
        frames(60);
        btn = 2'b01; tick();
        chk("press_timer_done", state, 3'b001);
        btn = 2'b00;
        miss = 1'b1; tick(); miss = 1'b0;
        chk("miss2_state", state, 3'b010);
        chk("miss2_balls", balls_left, 4'd0);
        frames(120);
        btn = 2'b01; tick(); btn = 2'b00;
        chk("play3_state", state, 3'b001);
        miss = 1'b1; tick(); miss = 1'b0;
        chk("miss3_over", state, 3'b011);
        chk("over_score_held", score, 8'h99);
        video_on = 1'b1; text_on = 4'b0001; graph_on = 1'b1; pixel_tick = 1'b1;
        tick();
        chk("over_rgb_text", rgb, 3'b101);
        video_on = 1'b0; text_on = 4'b0000; graph_on = 1'b0; pixel_tick = 1'b0;
        frames(119);
        chk("over_wait", state, 3'b011);
        frame_tick = 1'b1; tick(); frame_tick = 1'b0;
        chk("over_last_frame", state, 3'b011);
        tick();
        chk("over_to_newgame", state, 3'b000);
        tick();
        chk("newgame_score_clr", score, 8'h00);
        chk("newgame_balls", balls_left, 4'd3);

        // RGB layering table, registered only on pixel_tick
        prev_rgb = 3'b101;
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].play && state != 3'b001) begin
                btn = 2'b01; tick(); btn = 2'b00; tick();
            end
            video_on = vecs[i].vid; text_on = vecs[i].txt; graph_on = vecs[i].gon;
            pixel_tick = 1'b0; tick();
            chk($sformatf("rgb_hold_%0d", i), rgb, prev_rgb);
            pixel_tick = 1'b1; tick(); pixel_tick = 1'b0;
            chk($sformatf("rgb_vec_%0d", i), rgb, vecs[i].exp_rgb);
            prev_rgb = vecs[i].exp_rgb;
        end
        video_on = 1'b0; text_on = 4'b0000; graph_on = 1'b0;

`ifdef GAME_PAUSE_EN
        pulse_hit();
        chk("pause_pre_score", score, 8'h01);
        pause_btn = 1'b1; tick();
        chk("pause_enter", state, 3'b100);
        chk("pause_still", gra_still, 1'b1);
        pause_btn = 1'b0; tick();
        pulse_hit();
        chk("pause_hit_ignored", score, 8'h01);
        pause_btn = 1'b1; tick(); pause_btn = 1'b0;
        chk("pause_exit", state, 3'b001);
`endif

        // Randomized run against the reference model, with an async reset mid-run
        reset = 1'b1; btn = 2'b00; pause_btn = 1'b0;
        #2;
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            if (c == 2000) begin
                reset = 1'b1;
                #1;
                chk("async_reset_state", state, 3'b000);
                chk("async_reset_balls", balls_left, 4'd3);
                chk("async_reset_score", score, 8'h00);
                reset = 1'b0;
                model_reset();
            end
            btn        = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            hit        = ($urandom_range(0, 2) == 0);
            miss       = ($urandom_range(0, 29) == 0);
            frame_tick = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 49) == 0) pause_btn = ~pause_btn;
            model_step();
            tick();
            chk($sformatf("rand_%0d", c), {state, score, balls_left, gra_still},
                {3'(m_mode), to_bcd(m_score), 4'(m_balls), (m_mode != 1)});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
